// File: rtl/iiitb_rtc_pkg.sv
// Shared types and constants for the RTC time-set controller.
package iiitb_rtc_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_EDIT_HR,
        ST_EDIT_MIN,
        ST_EDIT_SEC,
        ST_COMMIT
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HR   = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

    // Packs a 0..99 decimal value as two BCD digits {tens, units}.
    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/iiitb_rtc_bcd2_inc.sv
// Two-digit BCD +1 with wrap to 00 once the value is at or above i_max.
module iiitb_rtc_bcd2_inc
    import iiitb_rtc_pkg::*;
(
    input  logic [3:0] i_msd,
    input  logic [3:0] i_lsd,
    input  logic [7:0] i_max,
    output logic [3:0] o_msd,
    output logic [3:0] o_lsd
);

    // Packed BCD compares like decimal, so >= also catches out-of-range captures.
    always_comb begin
        o_msd = i_msd;
        o_lsd = i_lsd + 4'd1;
        if ({i_msd, i_lsd} >= i_max) begin
            o_msd = 4'd0;
            o_lsd = 4'd0;
        end else if (i_lsd >= 4'd9) begin
            o_msd = i_msd + 4'd1;
            o_lsd = 4'd0;
        end
    end

endmodule

// File: rtl/iiitb_rtc_set_ctrl.sv
// Button-driven hh:mm:ss edit sequencer: capture, edit per field, one-cycle load strobe.
module iiitb_rtc_set_ctrl
    import iiitb_rtc_pkg::*;
#(
    parameter int TIMEOUT_S = 10,
    parameter int HR_MAX    = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [3:0] hrm_i,
    input  logic [3:0] hrl_i,
    input  logic [3:0] minm_i,
    input  logic [3:0] minl_i,
    input  logic [3:0] secm_i,
    input  logic [3:0] secl_i,
    output logic       load_o,
    output logic [3:0] hrm_o,
    output logic [3:0] hrl_o,
    output logic [3:0] minm_o,
    output logic [3:0] minl_o,
    output logic [3:0] secm_o,
    output logic [3:0] secl_o,
    output logic [3:0] disp_hrm,
    output logic [3:0] disp_hrl,
    output logic [3:0] disp_minm,
    output logic [3:0] disp_minl,
    output logic [3:0] disp_secm,
    output logic [3:0] disp_secl,
    output logic [1:0] edit_sel,
    output logic       blink_o
);

    localparam logic [7:0] HR_MAX_BCD  = to_bcd8(HR_MAX);
    localparam logic [7:0] MIN_MAX_BCD = to_bcd8(MIN_MAX);
    localparam logic [7:0] SEC_MAX_BCD = to_bcd8(SEC_MAX);
    localparam logic [5:0] IDLE_LAST   = 6'(TIMEOUT_S - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_hr, r_min, r_sec;
    logic [7:0] r_ld_hr, r_ld_min, r_ld_sec;
    logic [5:0] r_idle;
    logic       r_blink;
    logic [7:0] w_hr_inc, w_min_inc, w_sec_inc;
    logic       w_in_edit, w_inc_ok, w_expire, w_to_quiet;

    iiitb_rtc_bcd2_inc u_hr_inc (
        .i_msd(r_hr[7:4]), .i_lsd(r_hr[3:0]), .i_max(HR_MAX_BCD),
        .o_msd(w_hr_inc[7:4]), .o_lsd(w_hr_inc[3:0])
    );
    iiitb_rtc_bcd2_inc u_min_inc (
        .i_msd(r_min[7:4]), .i_lsd(r_min[3:0]), .i_max(MIN_MAX_BCD),
        .o_msd(w_min_inc[7:4]), .o_lsd(w_min_inc[3:0])
    );
    iiitb_rtc_bcd2_inc u_sec_inc (
        .i_msd(r_sec[7:4]), .i_lsd(r_sec[3:0]), .i_max(SEC_MAX_BCD),
        .o_msd(w_sec_inc[7:4]), .o_lsd(w_sec_inc[3:0])
    );

    assign w_in_edit = (r_state == ST_EDIT_HR) || (r_state == ST_EDIT_MIN) ||
                       (r_state == ST_EDIT_SEC);
    assign w_inc_ok  = w_in_edit && inc_btn && !mode_btn;
    // Expiry lands on the same edge the idle count would reach TIMEOUT_S; any button defers it.
    assign w_expire  = w_in_edit && tick_1hz && !mode_btn && !inc_btn && (r_idle >= IDLE_LAST);

    always_comb begin
        w_state_nxt = r_state;
        edit_sel    = SEL_NONE;
        case (r_state)
            ST_RUN: begin
                if (mode_btn) w_state_nxt = ST_EDIT_HR;
            end
            ST_EDIT_HR: begin
                edit_sel = SEL_HR;
                if (mode_btn)      w_state_nxt = ST_EDIT_MIN;
                else if (w_expire) w_state_nxt = ST_RUN;
            end
            ST_EDIT_MIN: begin
                edit_sel = SEL_MIN;
                if (mode_btn)      w_state_nxt = ST_EDIT_SEC;
                else if (w_expire) w_state_nxt = ST_RUN;
            end
            ST_EDIT_SEC: begin
                edit_sel = SEL_SEC;
                if (mode_btn)      w_state_nxt = ST_COMMIT;
                else if (w_expire) w_state_nxt = ST_RUN;
            end
            ST_COMMIT: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    assign w_to_quiet = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_COMMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_hr     <= 8'h00;
            r_min    <= 8'h00;
            r_sec    <= 8'h00;
            r_ld_hr  <= 8'h00;
            r_ld_min <= 8'h00;
            r_ld_sec <= 8'h00;
            r_idle   <= 6'd0;
            r_blink  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_RUN && mode_btn) begin
                r_hr  <= {hrm_i, hrl_i};
                r_min <= {minm_i, minl_i};
                r_sec <= {secm_i, secl_i};
            end else if (w_inc_ok) begin
                case (r_state)
                    ST_EDIT_HR:  r_hr  <= w_hr_inc;
                    ST_EDIT_MIN: r_min <= w_min_inc;
                    ST_EDIT_SEC: r_sec <= w_sec_inc;
                    default: ;
                endcase
            end

            if (r_state == ST_EDIT_SEC && mode_btn) begin
                r_ld_hr  <= r_hr;
                r_ld_min <= r_min;
                r_ld_sec <= r_sec;
            end

            if (!w_in_edit || mode_btn || inc_btn || w_expire) r_idle <= 6'd0;
            else if (tick_1hz)                                 r_idle <= r_idle + 6'd1;

            if (w_to_quiet)             r_blink <= 1'b0;
            else if (r_state == ST_RUN) r_blink <= 1'b1;
            else if (w_inc_ok)          r_blink <= 1'b1;
            else if (tick_1hz)          r_blink <= ~r_blink;
        end
    end

    assign load_o  = (r_state == ST_COMMIT);
    assign blink_o = r_blink;
    assign {hrm_o, hrl_o}   = r_ld_hr;
    assign {minm_o, minl_o} = r_ld_min;
    assign {secm_o, secl_o} = r_ld_sec;

    always_comb begin
        if (w_in_edit) begin
            {disp_hrm, disp_hrl}   = r_hr;
            {disp_minm, disp_minl} = r_min;
            {disp_secm, disp_secl} = r_sec;
        end else begin
            {disp_hrm, disp_hrl}   = {hrm_i, hrl_i};
            {disp_minm, disp_minl} = {minm_i, minl_i};
            {disp_secm, disp_secl} = {secm_i, secl_i};
        end
    end

endmodule
